// File: rtl/riscv_pkg.sv
// Shared encodings and ALU operation set for the single-cycle RV32I-subset core.
package riscv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_PASSB
    } alu_op_t;

endpackage

// File: rtl/riscv_alu.sv
// Combinational 32-bit ALU; zero flag feeds the BEQ/BNE decision.
module riscv_alu
    import riscv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] y,
    output logic        zero
);

    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_SLT:   y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLL:   y = a << b[4:0];
            ALU_SRL:   y = a >> b[4:0];
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/riscv_processor.sv
// Single-cycle RV32I-subset core: fetch, decode, execute, memory and
// writeback all resolve within one clock; imem/dmem/rf are internal.
module riscv_processor
    import riscv_pkg::*;
#(
    parameter int    IMEM_WORDS = 64,
    parameter int    DMEM_WORDS = 64,
    parameter string IMEM_INIT  = "program.hex"
) (
    input logic clock,
    input logic reset
);

    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_sel_t;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rf   [32];
    logic [31:0] pc;

    // Memory images exist from time 0; dmem survives reset by design.
    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) imem[i] = NOP_INSTR;
        for (int i = 0; i < DMEM_WORDS; i++) dmem[i] = '0;
    end

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    assign instr  = imem[pc[IW+1:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20],
                    instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    logic is_r;
    logic is_i;
    logic is_lw;
    logic is_sw;
    logic is_br;
    logic is_jal;
    logic is_lui;

    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_br  = (opcode == OP_BR);
    assign is_jal = (opcode == OP_JAL);
    assign is_lui = (opcode == OP_LUI);

    alu_op_t     alu_op;
    wb_sel_t     wb_sel;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_we;
    logic        mem_we;
    logic        branch;
    logic        br_ne;
    logic        jump;

    // Unlisted funct encodings leave every enable low, i.e. a NOP.
    always_comb begin
        alu_op  = ALU_ADD;
        wb_sel  = WB_ALU;
        imm     = imm_i;
        use_imm = 1'b0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        branch  = 1'b0;
        br_ne   = 1'b0;
        jump    = 1'b0;
        unique case (1'b1)
            is_r: begin
                reg_we = 1'b1;
                unique case ({funct7, funct3})
                    {F7_BASE, F3_ADD}: alu_op = ALU_ADD;
                    {F7_ALT,  F3_ADD}: alu_op = ALU_SUB;
                    {F7_BASE, F3_AND}: alu_op = ALU_AND;
                    {F7_BASE, F3_OR}:  alu_op = ALU_OR;
                    {F7_BASE, F3_XOR}: alu_op = ALU_XOR;
                    {F7_BASE, F3_SLT}: alu_op = ALU_SLT;
                    {F7_BASE, F3_SLL}: alu_op = ALU_SLL;
                    {F7_BASE, F3_SRL}: alu_op = ALU_SRL;
                    default:           reg_we = 1'b0;
                endcase
            end
            is_i: begin
                use_imm = 1'b1;
                reg_we  = 1'b1;
                unique case (funct3)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_AND:  alu_op = ALU_AND;
                    F3_OR:   alu_op = ALU_OR;
                    default: reg_we = 1'b0;
                endcase
            end
            is_lw: begin
                use_imm = 1'b1;
                wb_sel  = WB_MEM;
                reg_we  = (funct3 == F3_W);
            end
            is_sw: begin
                use_imm = 1'b1;
                imm     = imm_s;
                mem_we  = (funct3 == F3_W);
            end
            is_br: begin
                alu_op = ALU_SUB;
                branch = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
                br_ne  = (funct3 == F3_BNE);
            end
            is_jal: begin
                jump   = 1'b1;
                reg_we = 1'b1;
                wb_sel = WB_PC4;
            end
            is_lui: begin
                use_imm = 1'b1;
                imm     = imm_u;
                alu_op  = ALU_PASSB;
                reg_we  = 1'b1;
            end
            default: ;
        endcase
    end

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        alu_zero;

    assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];
    assign alu_b   = use_imm ? imm : rs2_val;

    riscv_alu u_alu (
        .a    (rs1_val),
        .b    (alu_b),
        .op   (alu_op),
        .y    (alu_y),
        .zero (alu_zero)
    );

    logic [31:0]   pc_plus4;
    logic [31:0]   pc_next;
    logic [31:0]   wb_val;
    logic [DW-1:0] dmem_idx;
    logic          taken;

    assign pc_plus4 = pc + 32'd4;
    assign taken    = branch && (alu_zero ^ br_ne);
    assign dmem_idx = alu_y[DW+1:2];

    always_comb begin
        pc_next = pc_plus4;
        if (jump)
            pc_next = pc + imm_j;
        else if (taken)
            pc_next = pc + imm_b;
    end

    always_comb begin
        wb_val = alu_y;
        unique case (wb_sel)
            WB_MEM:  wb_val = dmem[dmem_idx];
            WB_PC4:  wb_val = pc_plus4;
            default: wb_val = alu_y;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            pc <= pc_next;
            if (reg_we && rd != 5'd0) rf[rd] <= wb_val;
        end
    end

    // No reset on dmem; a store racing reset assertion is suppressed.
    always @(posedge clock) begin
        if (reset && mem_we) dmem[dmem_idx] <= rs2_val;
    end

endmodule

// File: tb/tb_riscv_processor.sv
// Scoreboard bench: an instruction-level model predicts each commit,
// a monitor compares the core's architectural state after every edge.
module tb_riscv_processor;

    localparam logic [6:0] OPC_R   = 7'h33;
    localparam logic [6:0] OPC_I   = 7'h13;
    localparam logic [6:0] OPC_LW  = 7'h03;
    localparam logic [6:0] OPC_SW  = 7'h23;
    localparam logic [6:0] OPC_BR  = 7'h63;
    localparam logic [6:0] OPC_JAL = 7'h6f;
    localparam logic [6:0] OPC_LUI = 7'h37;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    riscv_processor #(
        .IMEM_WORDS (64),
        .DMEM_WORDS (64),
        .IMEM_INIT  ("")
    ) dut (
        .clock (clock),
        .reset (reset)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rd_val;
        bit          st;
        int          st_idx;
        logic [31:0] st_val;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          running  = 1'b0;
    logic [31:0] m_imem [64];
    logic [31:0] m_dmem [64];
    logic [31:0] m_rf   [32];
    logic [31:0] m_pc;
    logic [31:0] prog   [64];

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [2:0] f3,
                                          int rd, int rs1, int rs2);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), OPC_R};
    endfunction

    function automatic logic [31:0] enc_i(logic [6:0] op, logic [2:0] f3,
                                          int rd, int rs1, int imm);
        return {12'(imm), 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(int rs2, int rs1, int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'd2, v[4:0], OPC_SW};
    endfunction

    function automatic logic [31:0] enc_b(logic [2:0] f3, int rs1, int rs2,
                                          int imm);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3,
                v[4:1], v[11], OPC_BR};
    endfunction

    function automatic logic [31:0] enc_j(int rd, int imm);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), OPC_JAL};
    endfunction

    function automatic logic [31:0] enc_u(int rd, int imm20);
        return {20'(imm20), 5'(rd), OPC_LUI};
    endfunction

    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i(OPC_I, 3'd0, rd, rs1, imm);
    endfunction

    function automatic int nz_off(int o);
        return (o == 0) ? 8 : o;
    endfunction

    function automatic logic [31:0] rand_instr();
        int         k;
        int         rd;
        int         rs1;
        int         rs2;
        logic [2:0] f3;
        k   = int'($urandom_range(0, 15));
        rd  = int'($urandom_range(0, 7));
        rs1 = int'($urandom_range(0, 7));
        rs2 = int'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        case (k)
            0, 1, 2: return enc_r(($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00,
                                  f3, rd, rs1, rs2);
            3, 4:    return enc_i(OPC_I, f3, rd, rs1,
                                  int'($urandom_range(0, 4095)) - 2048);
            5:       return enc_u(rd, int'($urandom));
            6:       return enc_i(OPC_LW, 3'd2, rd, rs1,
                                  int'($urandom_range(0, 511)) - 256);
            7:       return enc_s(rs2, rs1, int'($urandom_range(0, 511)) - 256);
            8, 9:    return enc_b(3'($urandom_range(0, 1)), rs1, rs2,
                                  nz_off((int'($urandom_range(0, 32)) - 16) * 2));
            10:      return enc_j(rd, nz_off((int'($urandom_range(0, 64)) - 32) * 4));
            11:      return $urandom;
            default: return addi(rd, 0, int'($urandom_range(0, 63)));
        endcase
    endfunction

    // Architectural reference: one instruction per call, RV32I semantics.
    task automatic model_step();
        logic [31:0] ins, a, b, res, npc, addr;
        logic [31:0] imm_i, imm_s, imm_b, imm_j;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        int          si, rd, rs1, rs2, idx;
        bit          wr;
        exp_t        e;
        ins   = m_imem[(m_pc >> 2) % 64];
        si    = int'(ins);
        op    = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        rd    = int'(ins[11:7]);
        rs1   = int'(ins[19:15]);
        rs2   = int'(ins[24:20]);
        a     = m_rf[rs1];
        b     = m_rf[rs2];
        imm_i = si >>> 20;
        imm_s = (si >>> 25) * 32 + int'(ins[11:7]);
        imm_b = (si >>> 31) * 4096 + int'(ins[7]) * 2048
              + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        imm_j = (si >>> 31) * 1048576 + int'(ins[19:12]) * 4096
              + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        npc      = m_pc + 4;
        wr       = 1'b0;
        res      = '0;
        e.st     = 1'b0;
        e.st_idx = 0;
        e.st_val = '0;
        case (op)
            OPC_R: begin
                wr = 1'b1;
                if (f7 == 7'h00 && f3 == 3'd0) res = a + b;
                else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
                else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
                else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
                else if (f7 == 7'h00 && f3 == 3'd4) res = a ^ b;
                else if (f7 == 7'h00 && f3 == 3'd2)
                    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                else if (f7 == 7'h00 && f3 == 3'd1) res = a << (b % 32);
                else if (f7 == 7'h00 && f3 == 3'd5) res = a >> (b % 32);
                else wr = 1'b0;
            end
            OPC_I: begin
                wr = 1'b1;
                if (f3 == 3'd0) res = a + imm_i;
                else if (f3 == 3'd7) res = a & imm_i;
                else if (f3 == 3'd6) res = a | imm_i;
                else wr = 1'b0;
            end
            OPC_LW: if (f3 == 3'd2) begin
                addr = a + imm_i;
                wr   = 1'b1;
                res  = m_dmem[(addr >> 2) % 64];
            end
            OPC_SW: if (f3 == 3'd2) begin
                addr         = a + imm_s;
                idx          = int'((addr >> 2) % 64);
                m_dmem[idx]  = b;
                e.st         = 1'b1;
                e.st_idx     = idx;
                e.st_val     = b;
            end
            OPC_BR: begin
                if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b))
                    npc = m_pc + imm_b;
            end
            OPC_JAL: begin
                wr  = 1'b1;
                res = m_pc + 4;
                npc = m_pc + imm_j;
            end
            OPC_LUI: begin
                wr  = 1'b1;
                res = ins & 32'hFFFFF000;
            end
            default: ;
        endcase
        if (wr && rd != 0) m_rf[rd] = res;
        m_pc     = npc;
        e.pc     = npc;
        e.rd     = (wr && rd != 0) ? 5'(rd) : 5'd0;
        e.rd_val = res;
        sb.push_back(e);
    endtask

    always @(posedge clock) begin
        exp_t e;
        if (running) begin
            #1;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: commit with empty queue, pc %h",
                         dut.pc);
            end else begin
                e = sb.pop_front();
                check("commit_pc", dut.pc, e.pc);
                check("x0_zero", dut.rf[0], 32'd0);
                if (e.rd != 5'd0)
                    check($sformatf("commit_x%0d", e.rd), dut.rf[e.rd],
                          e.rd_val);
                if (e.st)
                    check($sformatf("store_dmem%0d", e.st_idx),
                          dut.dmem[e.st_idx], e.st_val);
            end
        end
    end

    task automatic run(int n);
        running = 1'b1;
        repeat (n) begin
            model_step();
            @(posedge clock);
            #2;
        end
        running = 1'b0;
        check("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'h00000013;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) begin
            dut.imem[i] = prog[i];
            m_imem[i]   = prog[i];
        end
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
    endtask

    task automatic check_reset_state();
        check("reset_pc", dut.pc, 32'd0);
        for (int i = 0; i < 32; i++)
            check($sformatf("reset_x%0d", i), dut.rf[i], 32'd0);
    endtask

    task automatic full_check();
        check("final_pc", dut.pc, m_pc);
        for (int i = 0; i < 32; i++)
            check($sformatf("final_x%0d", i), dut.rf[i], m_rf[i]);
        for (int i = 0; i < 64; i++)
            check($sformatf("final_dmem%0d", i), dut.dmem[i], m_dmem[i]);
    endtask

    // Asynchronous assertion between edges, then release before the next edge.
    task automatic do_reset();
        #1;
        reset = 1'b0;
        #1;
        check_reset_state();
        for (int i = 0; i < 64; i++)
            check($sformatf("kept_dmem%0d", i), dut.dmem[i], m_dmem[i]);
        load_prog();
        @(negedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_dmem[i] = '0;
        #1;
        clear_prog();
        prog[0] = addi(1, 0, 5);
        prog[1] = addi(2, 0, -3);
        prog[2] = enc_r(7'h00, 3'd0, 3, 1, 2);
        prog[3] = enc_r(7'h20, 3'd0, 4, 1, 2);
        prog[4] = enc_r(7'h00, 3'd2, 5, 2, 1);
        load_prog();
        #3;
        check_reset_state();
        #6;
        reset = 1'b1;
        run(5);
        check("arith_x1", dut.rf[1], 32'd5);
        check("arith_x2", dut.rf[2], 32'hFFFFFFFD);
        check("arith_x3", dut.rf[3], 32'd2);
        check("arith_x4", dut.rf[4], 32'd8);
        check("arith_x5", dut.rf[5], 32'd1);
        full_check();

        clear_prog();
        prog[0] = addi(1, 0, 32'h55);
        prog[1] = enc_s(1, 0, 8);
        prog[2] = enc_i(OPC_LW, 3'd2, 6, 0, 8);
        do_reset();
        run(3);
        check("mem_dmem2", dut.dmem[2], 32'h55);
        check("mem_x6", dut.rf[6], 32'h55);

        clear_prog();
        prog[0] = addi(1, 0, 1);
        prog[1] = enc_b(3'd0, 1, 0, 8);
        prog[2] = enc_b(3'd1, 1, 0, 8);
        prog[3] = addi(9, 0, 7);
        prog[4] = addi(10, 0, 2);
        do_reset();
        run(4);
        check("br_skipped_x9", dut.rf[9], 32'd0);
        check("br_x10", dut.rf[10], 32'd2);
        check("br_pc", dut.pc, 32'd20);

        clear_prog();
        prog[4] = enc_j(7, 12);
        prog[7] = enc_u(8, 32'h12345);
        do_reset();
        run(5);
        check("jal_x7", dut.rf[7], 32'h14);
        check("jal_pc", dut.pc, 32'h1C);
        run(1);
        check("lui_x8", dut.rf[8], 32'h12345000);

        clear_prog();
        prog[0] = addi(0, 0, 9);
        prog[1] = 32'hFFFFFFFF;
        do_reset();
        run(1);
        check("x0_after_addi", dut.rf[0], 32'd0);
        run(1);
        check("illegal_pc", dut.pc, 32'd8);
        full_check();

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++) prog[i] = rand_instr();
            do_reset();
            run(150);
            full_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
